// File: rtl/design1_wrapper.sv
// AXI4-Lite slave holding three read/write registers and a read-only checksum
// register (REG0 + REG1 + REG2, mod 2^32) at word 3.
module design1_wrapper #(
   parameter int C_ADDR_WIDTH = 4,
   parameter int C_DATA_WIDTH = 32
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [C_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [2:0]                  s_axi_awprot,
   input  logic                        s_axi_awvalid,
   output logic                        s_axi_awready,
   input  logic [C_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [C_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                        s_axi_wvalid,
   output logic                        s_axi_wready,
   output logic [1:0]                  s_axi_bresp,
   output logic                        s_axi_bvalid,
   input  logic                        s_axi_bready,
   input  logic [C_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [2:0]                  s_axi_arprot,
   input  logic                        s_axi_arvalid,
   output logic                        s_axi_arready,
   output logic [C_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                  s_axi_rresp,
   output logic                        s_axi_rvalid,
   input  logic                        s_axi_rready
);

   // Handshake rule for every channel: a transfer happens on the rising edge
   // where both valid and ready are high; valid never waits on ready.

   logic [C_DATA_WIDTH-1:0] regs [3];
   logic [C_DATA_WIDTH-1:0] sum;
   logic [C_DATA_WIDTH-1:0] rd_mux;
   logic                    wr_ready;
   logic                    rd_ready;
   logic                    bvalid;
   logic                    rvalid;
   logic [C_DATA_WIDTH-1:0] rdata;
   logic                    wr_fire;
   logic                    rd_fire;
   logic [1:0]              wr_idx;
   logic [1:0]              rd_idx;
   logic                    unused_ok;

   assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   assign wr_idx  = s_axi_awaddr[3:2];
   assign rd_idx  = s_axi_araddr[3:2];
   assign wr_fire = wr_ready && s_axi_awvalid && s_axi_wvalid;
   assign rd_fire = rd_ready && s_axi_arvalid;
   assign sum     = regs[0] + regs[1] + regs[2];

   always_comb begin
      rd_mux = sum;
      case (rd_idx)
         2'd0:    rd_mux = regs[0];
         2'd1:    rd_mux = regs[1];
         2'd2:    rd_mux = regs[2];
         default: rd_mux = sum;
      endcase
   end

   // Ready is offered only once both AW and W are present and the response
   // slot is (or is about to be) free, which allows one write every 2 cycles.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ready <= 1'b0;
         bvalid   <= 1'b0;
         regs[0]  <= '0;
         regs[1]  <= '0;
         regs[2]  <= '0;
      end else begin
         wr_ready <= s_axi_awvalid && s_axi_wvalid && !wr_ready && (!bvalid || s_axi_bready);
         if (wr_fire) begin
            if (wr_idx != 2'd3) begin
               for (int b = 0; b < C_DATA_WIDTH/8; b++) begin
                  if (s_axi_wstrb[b]) regs[wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
               end
            end
            bvalid <= 1'b1;
         end else if (s_axi_bready) begin
            bvalid <= 1'b0;
         end
      end
   end

   // Read data is captured at the AR handshake, so it stays stable under
   // backpressure and a same-edge write is not yet visible.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_ready <= 1'b0;
         rvalid   <= 1'b0;
         rdata    <= '0;
      end else begin
         rd_ready <= s_axi_arvalid && !rd_ready && (!rvalid || s_axi_rready);
         if (rd_fire) begin
            rdata  <= rd_mux;
            rvalid <= 1'b1;
         end else if (s_axi_rready) begin
            rvalid <= 1'b0;
         end
      end
   end

   assign s_axi_awready = wr_ready;
   assign s_axi_wready  = wr_ready;
   assign s_axi_bvalid  = bvalid;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_arready = rd_ready;
   assign s_axi_rvalid  = rvalid;
   assign s_axi_rdata   = rdata;
   assign s_axi_rresp   = 2'b00;

endmodule

// File: tb/tb_design1_wrapper.sv
// Bench for design1_wrapper: directed register-map scenarios plus randomized
// concurrent AXI4-Lite traffic, checked every cycle against a register model.
module tb_design1_wrapper;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [3:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [3:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;

   design1_wrapper #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
   );

   always #10 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   // Register model: three words plus a derived checksum.
   logic [31:0] m_reg [3];
   logic [31:0] exp_q [$];
   bit          b_pend = 1'b0;
   bit          prev_aw = 1'b0;
   bit          prev_ar = 1'b0;
   bit          drain = 1'b0;
   bit          stop = 1'b0;

   function automatic logic [31:0] model_read(input logic [3:0] addr);
      if (addr[3:2] == 2'd3) return m_reg[0] + m_reg[1] + m_reg[2];
      return m_reg[addr[3:2]];
   endfunction

   task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      if (addr[3:2] != 2'd3) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) m_reg[addr[3:2]][8*b +: 8] = data[8*b +: 8];
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'b0, act}, {31'b0, exp});
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=handshake at %0t", name, $time);
   endtask

   // Per-cycle compare process.
   always @(negedge aclk) begin
      if (!aresetn) begin
         m_reg[0] = '0; m_reg[1] = '0; m_reg[2] = '0;
         exp_q.delete();
         b_pend = 1'b0;
         prev_aw = 1'b0;
         prev_ar = 1'b0;
      end else begin
         chk1("aw_w_ready_together", awready, wready);
         if (awready) chk1("aw_accept_rule", awvalid && wvalid && !bvalid && !prev_aw, 1'b1);
         if (arready) chk1("ar_accept_rule", arvalid && !rvalid && !prev_ar, 1'b1);
         chk1("bvalid", bvalid, b_pend);
         if (bvalid) chk("bresp", {30'b0, bresp}, 32'd0);
         if (exp_q.size() > 0) begin
            chk1("rvalid", rvalid, 1'b1);
            chk("rdata", rdata, exp_q[0]);
            chk("rresp", {30'b0, rresp}, 32'd0);
         end else begin
            chk1("rvalid_idle", rvalid, 1'b0);
         end
         if (bvalid && bready) b_pend = 1'b0;
         if (rvalid && rready && exp_q.size() > 0) void'(exp_q.pop_front());
         // Read is sampled before the write so a same-edge pair sees old data.
         if (arready && arvalid) exp_q.push_back(model_read(araddr));
         if (awready && awvalid && wvalid) begin
            model_write(awaddr, wdata, wstrb);
            b_pend = 1'b1;
         end
         prev_aw = awready;
         prev_ar = arready;
      end
   end

   task automatic issue_aw_w(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb, input int lead);
      int n;
      @(posedge aclk); #1;
      awaddr = addr; wdata = data; wstrb = strb;
      if (lead > 0) begin
         wvalid = 1'b1;
         repeat (lead) begin @(posedge aclk); #1; end
         awvalid = 1'b1;
      end else if (lead < 0) begin
         awvalid = 1'b1;
         repeat (-lead) begin @(posedge aclk); #1; end
         wvalid = 1'b1;
      end else begin
         awvalid = 1'b1;
         wvalid = 1'b1;
      end
      n = 0;
      @(negedge aclk);
      while (!awready && n < 100) begin n++; @(negedge aclk); end
      if (!awready) timeout_fail("aw_w_accept");
      @(posedge aclk); #1;
      awvalid = 1'b0;
      wvalid = 1'b0;
   endtask

   task automatic issue_ar(input logic [3:0] addr);
      int n;
      @(posedge aclk); #1;
      araddr = addr;
      arvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!arready && n < 100) begin n++; @(negedge aclk); end
      if (!arready) timeout_fail("ar_accept");
      @(posedge aclk); #1;
      arvalid = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int bp, output logic [1:0] resp);
      int n;
      issue_aw_w(addr, data, strb, lead);
      n = 0;
      while (!bvalid && n < 100) begin n++; @(negedge aclk); end
      if (!bvalid) timeout_fail("b_valid");
      repeat (bp) @(posedge aclk);
      #1 bready = 1'b1;
      @(negedge aclk);
      resp = bresp;
      @(posedge aclk); #1;
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] addr, input int bp, output logic [31:0] data, output logic [1:0] resp);
      int n;
      issue_ar(addr);
      n = 0;
      while (!rvalid && n < 100) begin n++; @(negedge aclk); end
      if (!rvalid) timeout_fail("r_valid");
      repeat (bp) @(posedge aclk);
      #1 rready = 1'b1;
      @(negedge aclk);
      data = rdata;
      resp = rresp;
      @(posedge aclk); #1;
      rready = 1'b0;
   endtask

   task automatic read_expect(input string name, input logic [3:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      logic [1:0]  r;
      do_read(addr, 0, d, r);
      chk(name, d, exp);
      chk({name, "_resp"}, {30'b0, r}, 32'd0);
   endtask

   task automatic write_ok(input string name, input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead);
      logic [1:0] r;
      do_write(addr, data, strb, lead, 0, r);
      chk({name, "_bresp"}, {30'b0, r}, 32'd0);
   endtask

   initial begin
      logic [31:0] d0, d1;
      logic [1:0]  r0, r1;
      int          n;

      #300;
      chk1("rst_awready", awready, 1'b0);
      chk1("rst_wready", wready, 1'b0);
      chk1("rst_bvalid", bvalid, 1'b0);
      chk1("rst_arready", arready, 1'b0);
      chk1("rst_rvalid", rvalid, 1'b0);
      chk("rst_rdata", rdata, 32'h0);
      #40 aresetn = 1'b1;
      repeat (2) @(posedge aclk);

      read_expect("rst_reg0", 4'h0, 32'h0);
      read_expect("rst_reg1", 4'h4, 32'h0);
      read_expect("rst_reg2", 4'h8, 32'h0);
      read_expect("rst_sum", 4'hC, 32'h0);

      write_ok("wr_reg0", 4'h0, 32'hDEADBEEF, 4'hF, 0);
      write_ok("wr_reg1", 4'h4, 32'h0000BEEF, 4'hF, 0);
      write_ok("wr_reg2", 4'h8, 32'hDEAD0000, 4'hF, 0);
      read_expect("rd_reg0", 4'h0, 32'hDEADBEEF);
      read_expect("rd_reg1", 4'h4, 32'h0000BEEF);
      read_expect("rd_reg2", 4'h8, 32'hDEAD0000);
      read_expect("rd_sum", 4'hC, 32'hBD5B7DDE);

      write_ok("wr_sum_ro", 4'hC, 32'h12345678, 4'hF, 0);
      read_expect("rd_sum_ro", 4'hC, 32'hBD5B7DDE);

      write_ok("wr_strb", 4'h4, 32'hAABBCCDD, 4'b1010, 0);
      read_expect("rd_strb", 4'h4, 32'hAA00CCEF);
      read_expect("rd_unaligned", 4'h7, 32'hAA00CCEF);
      read_expect("rd_sum2", 4'hC, 32'h675B8BDE);

      // Same-cycle read and write of REG0.
      fork
         do_write(4'h1, 32'h11111111, 4'hF, 0, 0, r0);
         do_read(4'h0, 0, d0, r1);
      join
      chk("same_cycle_old", d0, 32'hDEADBEEF);
      read_expect("same_cycle_new", 4'h0, 32'h11111111);

      // W leads AW by 3 cycles.
      write_ok("w_first", 4'h8, 32'h22222222, 4'hF, 3);
      read_expect("rd_w_first", 4'h8, 32'h22222222);

      // Both responses held off for 5 cycles.
      fork
         do_write(4'h4, 32'h33333333, 4'hF, 0, 5, r0);
         do_read(4'hC, 5, d1, r1);
      join
      chk("bp_sum_pre_write", d1, 32'h11111111 + 32'hAA00CCEF + 32'h22222222);
      read_expect("bp_reg1", 4'h4, 32'h33333333);

      // Reset during an outstanding write response.
      issue_aw_w(4'h4, 32'h44444444, 4'hF, 0);
      n = 0;
      while (!bvalid && n < 100) begin n++; @(negedge aclk); end
      chk1("mid_bvalid_before", bvalid, 1'b1);
      #5 aresetn = 1'b0;
      #1;
      chk1("mid_bvalid_drop", bvalid, 1'b0);
      chk1("mid_awready", awready, 1'b0);
      repeat (2) @(posedge aclk);
      #3 aresetn = 1'b1;
      repeat (2) @(posedge aclk);
      read_expect("mid_reg0", 4'h0, 32'h0);
      read_expect("mid_reg1", 4'h4, 32'h0);
      read_expect("mid_sum", 4'hC, 32'h0);

      // Randomized concurrent traffic with random backpressure.
      fork
         begin
            fork
               for (int i = 0; i < 150; i++) begin
                  issue_aw_w(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                             int'($urandom_range(0, 6)) - 3);
                  repeat ($urandom_range(0, 2)) @(posedge aclk);
               end
               for (int i = 0; i < 150; i++) begin
                  issue_ar(4'($urandom_range(0, 15)));
                  repeat ($urandom_range(0, 2)) @(posedge aclk);
               end
            join
            drain = 1'b1;
            repeat (3) @(posedge aclk);
            n = 0;
            while ((bvalid || rvalid) && n < 50) begin n++; @(posedge aclk); end
            chk1("drain_idle", bvalid || rvalid, 1'b0);
            stop = 1'b1;
         end
         while (!stop) begin
            @(posedge aclk); #1;
            bready = drain || ($urandom_range(0, 3) != 0);
         end
         while (!stop) begin
            @(posedge aclk); #1;
            rready = drain || ($urandom_range(0, 3) != 0);
         end
      join
      bready = 1'b0;
      rready = 1'b0;
      @(negedge aclk);
      chk("exp_q_empty", exp_q.size(), 32'd0);
      chk1("b_pend_clear", b_pend, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
